// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file sequencer.
// Contents: sequencer state encoding, ALU op codes, the legal-op check and
// the bit positions of the instruction-register fields.
package cpu_pkg;

    // Sequencer states: one operation walks IDLE -> SETUP -> WRITE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2
    } seq_state_e;

    // ALU op codes carried in the instruction op field
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_XNOR = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;

    // Instruction-register field bit positions
    localparam int LIT_BIT = 30;
    localparam int OP_HI   = 29;
    localparam int OP_LO   = 26;
    localparam int RC_HI   = 25;
    localparam int RC_LO   = 21;
    localparam int RA_HI   = 20;
    localparam int RA_LO   = 16;
    localparam int RB_HI   = 15;
    localparam int RB_LO   = 11;
    localparam int LIT_HI  = 15;
    localparam int LIT_LO  = 0;

    // Returns 1 when the op code is one the ALU implements
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_XNOR, OP_SHL, OP_SHR, OP_SRA: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// Ports: clk, rst (sync, active-high), en (grants allowed this cycle),
//        req_ld / req_ins (requests), gnt_ld / gnt_ins (one-hot-or-zero grants).
// A lone requester is granted outright; under contention the requester that
// was not granted last wins. After reset the load requester wins first.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_ld,
    input  logic req_ins,
    output logic gnt_ld,
    output logic gnt_ins
);

    logic prio_ld_r;

    // Grant decision from current requests and the priority pointer
    always_comb begin
        gnt_ld  = 1'b0;
        gnt_ins = 1'b0;
        if (en) begin
            if (req_ld && req_ins) begin
                if (prio_ld_r) begin
                    gnt_ld = 1'b1;
                end else begin
                    gnt_ins = 1'b1;
                end
            end else begin
                gnt_ld  = req_ld;
                gnt_ins = req_ins;
            end
        end else begin
            gnt_ld  = 1'b0;
            gnt_ins = 1'b0;
        end
    end

    // Priority pointer: after any grant the other requester is favoured
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ld_r <= 1'b1;
        end else if (gnt_ld) begin
            prio_ld_r <= 1'b0;
        end else if (gnt_ins) begin
            prio_ld_r <= 1'b1;
        end else begin
            prio_ld_r <= prio_ld_r;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Sequences register-file writes into a DataPath from two sources: ALU
// instructions and direct register loads.
// Ports: clk, rst (sync, active-high); ins_valid/ins_ready/ins_word (ALU
//        instruction handshake); ld_valid/ld_ready/ld_reg/ld_data (register
//        load handshake); dp_ir/dp_data/dp_wen/dp_sel (DataPath controls);
//        busy (not IDLE), illegal (pulse on rejected op), retired (write count).
// Each accepted request takes SETUP then WRITE; dp_wen is high only in WRITE.
// The ready outputs are the arbiter grants, only offered while IDLE and not
// in reset, so a request is accepted on the edge where valid and ready meet.
module datapath_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [WIDTH-1:0] ins_word,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_reg,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] dp_ir,
    output logic [WIDTH-1:0] dp_data,
    output logic             dp_wen,
    output logic             dp_sel,
    output logic             busy,
    output logic             illegal,
    output logic [15:0]      retired
);

    seq_state_e       state_r;
    logic [WIDTH-1:0] dp_ir_r;
    logic [WIDTH-1:0] dp_data_r;
    logic             dp_wen_r;
    logic             dp_sel_r;
    logic             busy_r;
    logic             illegal_r;
    logic [15:0]      retired_r;

    logic             arb_en_s;
    logic             gnt_ld_s;
    logic             gnt_ins_s;
    logic [WIDTH-1:0] ld_ir_s;

    assign arb_en_s = (state_r == ST_IDLE) && !rst;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (arb_en_s),
        .req_ld  (ld_valid),
        .req_ins (ins_valid),
        .gnt_ld  (gnt_ld_s),
        .gnt_ins (gnt_ins_s)
    );

    // IR image for a load: only the destination field Rc is populated
    always_comb begin
        ld_ir_s              = {WIDTH{1'b0}};
        ld_ir_s[RC_HI:RC_LO] = ld_reg;
    end

    // Sequencer FSM with all DataPath controls registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            dp_ir_r   <= {WIDTH{1'b0}};
            dp_data_r <= {WIDTH{1'b0}};
            dp_wen_r  <= 1'b0;
            dp_sel_r  <= 1'b0;
            busy_r    <= 1'b0;
            illegal_r <= 1'b0;
            retired_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dp_wen_r  <= 1'b0;
                    illegal_r <= 1'b0;
                    if (gnt_ld_s) begin
                        state_r   <= ST_SETUP;
                        busy_r    <= 1'b1;
                        dp_ir_r   <= ld_ir_s;
                        dp_data_r <= ld_data;
                        dp_sel_r  <= 1'b1;
                    end else if (gnt_ins_s) begin
                        state_r   <= ST_SETUP;
                        busy_r    <= 1'b1;
                        dp_ir_r   <= ins_word;
                        dp_data_r <= {WIDTH{1'b0}};
                        dp_sel_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    // Loads are always legal; instructions are screened here
                    if (!dp_sel_r && !is_legal_op(dp_ir_r[OP_HI:OP_LO])) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        illegal_r <= 1'b1;
                        dp_wen_r  <= 1'b0;
                    end else begin
                        state_r   <= ST_WRITE;
                        busy_r    <= 1'b1;
                        illegal_r <= 1'b0;
                        dp_wen_r  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    dp_wen_r  <= 1'b0;
                    illegal_r <= 1'b0;
                    retired_r <= retired_r + 16'd1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    dp_wen_r  <= 1'b0;
                    illegal_r <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready  = gnt_ld_s;
    assign ins_ready = gnt_ins_s;
    assign dp_ir     = dp_ir_r;
    assign dp_data   = dp_data_r;
    assign dp_wen    = dp_wen_r;
    assign dp_sel    = dp_sel_r;
    assign busy      = busy_r;
    assign illegal   = illegal_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_datapath_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [31:0] ins_word = 32'd0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_reg = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic [31:0] dp_ir;
    logic [31:0] dp_data;
    logic        dp_wen;
    logic        dp_sel;
    logic        busy;
    logic        illegal;
    logic [15:0] retired;

    datapath_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
        .dp_ir(dp_ir), .dp_data(dp_data), .dp_wen(dp_wen), .dp_sel(dp_sel),
        .busy(busy), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] exp_ret = 16'd0;
    logic        prefer_ld = 1'b1;

    // Observations captured over the three cycles after a grant
    logic [31:0] ir_o [3];
    logic [31:0] data_o [3];
    logic        sel_o [3];
    logic        wen_o [3];
    logic        ill_o [3];
    logic        busy_o [3];
    logic [15:0] ret_o [3];
    logic        got_ld, got_ins, bsy_rdy;
    int          gcyc;

    function automatic logic model_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010,
                          4'b1011, 4'b1100, 4'b1101, 4'b1110};
    endfunction

    function automatic logic [31:0] make_word(input logic [3:0] op, input logic [4:0] rc,
                                              input logic [4:0] ra, input logic [4:0] rb);
        return (32'(op) << OP_LO) | (32'(rc) << RC_LO) | (32'(ra) << RA_LO) | (32'(rb) << RB_LO);
    endfunction

    // Stimulus only: offer a request, wait (bounded) for the grant, record outputs
    task automatic drive_op(input logic vl, input logic vi, input logic [4:0] r,
                            input logic [31:0] d, input logic [31:0] w);
        got_ld = 1'b0; got_ins = 1'b0;
        ld_reg = r; ld_data = d; ins_word = w; ld_valid = vl; ins_valid = vi;
        for (int i = 0; i < 10; i++) begin
            #1;
            got_ld  = ld_valid & ld_ready;
            got_ins = ins_valid & ins_ready;
            @(posedge clk);
            if (got_ld || got_ins) break;
            #1;
        end
        #1;
        gcyc = cyc;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            ir_o[c] = dp_ir; data_o[c] = dp_data; sel_o[c] = dp_sel;
            wen_o[c] = dp_wen; ill_o[c] = illegal; busy_o[c] = busy; ret_o[c] = retired;
            if (c == 0) begin
                ld_valid = 1'b1; ins_valid = 1'b1;
                #1;
                bsy_rdy = ld_ready | ins_ready;
                ld_valid = 1'b0; ins_valid = 1'b0;
            end
        end
        ld_valid = 1'b0; ins_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 16'd0;
        prefer_ld = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_valid = 1'b1; ins_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dp_ir, dp_data, dp_wen, dp_sel, illegal, busy, retired} !== 86'd0)
            begin errors++; $display("FAIL reset_outputs: ir=%h data=%h wen=%b sel=%b ill=%b busy=%b ret=%h, need all zero",
                                     dp_ir, dp_data, dp_wen, dp_sel, illegal, busy, retired); end
        checks++;
        if ({ld_ready, ins_ready} !== 2'b00)
            begin errors++; $display("FAIL reset_ready: ld_ready=%b ins_ready=%b, need 00", ld_ready, ins_ready); end
        rst = 1'b0; ld_valid = 1'b0; ins_valid = 1'b0;
        exp_ret = 16'd0; prefer_ld = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        drive_op(1'b1, 1'b0, 5'd4, 32'h4, 32'h0);
        exp_ret = exp_ret + 16'd1;
        prefer_ld = 1'b0;
        checks++;
        if ({got_ld, got_ins} !== 2'b10)
            begin errors++; $display("FAIL load_grant: got ld=%b ins=%b, need 10", got_ld, got_ins); end
        checks++;
        if (ir_o[0] !== (32'd4 << RC_LO) || data_o[0] !== 32'h4 || sel_o[0] !== 1'b1)
            begin errors++; $display("FAIL load_latch: ir=%h data=%h sel=%b, need %h 00000004 1",
                                     ir_o[0], data_o[0], sel_o[0], 32'd4 << RC_LO); end
        checks++;
        if ({wen_o[0], wen_o[1], wen_o[2]} !== 3'b010)
            begin errors++; $display("FAIL load_wen: wen k+1..k+3=%b%b%b, need 010", wen_o[0], wen_o[1], wen_o[2]); end
        checks++;
        if (ret_o[2] !== exp_ret)
            begin errors++; $display("FAIL load_retired: got %h, need %h", ret_o[2], exp_ret); end
        checks++;
        if ({busy_o[0], busy_o[1], busy_o[2], bsy_rdy} !== 4'b1100)
            begin errors++; $display("FAIL load_busy: busy=%b%b%b ready_while_busy=%b, need 1100",
                                     busy_o[0], busy_o[1], busy_o[2], bsy_rdy); end
        checks++;
        if (ir_o[2] !== ir_o[0] || data_o[2] !== 32'h4 || sel_o[2] !== 1'b1)
            begin errors++; $display("FAIL load_hold: ir=%h data=%h sel=%b after write", ir_o[2], data_o[2], sel_o[2]); end
    endtask

    task automatic test_instr();
        logic [31:0] w;
        w = make_word(4'b0000, 5'd11, 5'd4, 5'd7);
        drive_op(1'b0, 1'b1, 5'd0, 32'h0, w);
        exp_ret = exp_ret + 16'd1;
        prefer_ld = 1'b1;
        checks++;
        if ({got_ld, got_ins} !== 2'b01)
            begin errors++; $display("FAIL instr_grant: got ld=%b ins=%b, need 01", got_ld, got_ins); end
        checks++;
        if (ir_o[0] !== w || data_o[0] !== 32'h0 || sel_o[0] !== 1'b0)
            begin errors++; $display("FAIL instr_latch: ir=%h data=%h sel=%b, need %h 0 0", ir_o[0], data_o[0], sel_o[0], w); end
        checks++;
        if ({wen_o[0], wen_o[1], wen_o[2]} !== 3'b010 || ret_o[2] !== exp_ret)
            begin errors++; $display("FAIL instr_wen: wen=%b%b%b ret=%h, need 010 ret=%h",
                                     wen_o[0], wen_o[1], wen_o[2], ret_o[2], exp_ret); end
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        w = make_word(4'b0111, 5'd3, 5'd1, 5'd2);
        drive_op(1'b0, 1'b1, 5'd0, 32'h0, w);
        prefer_ld = 1'b1;
        checks++;
        if ({ill_o[0], ill_o[1], ill_o[2]} !== 3'b010)
            begin errors++; $display("FAIL illegal_pulse: illegal=%b%b%b, need 010", ill_o[0], ill_o[1], ill_o[2]); end
        checks++;
        if ({wen_o[0], wen_o[1], wen_o[2]} !== 3'b000 || ret_o[2] !== exp_ret)
            begin errors++; $display("FAIL illegal_nowrite: wen=%b%b%b ret=%h, need 000 ret=%h",
                                     wen_o[0], wen_o[1], wen_o[2], ret_o[2], exp_ret); end
        checks++;
        if ({busy_o[0], busy_o[1]} !== 2'b10)
            begin errors++; $display("FAIL illegal_return: busy=%b%b, need 10", busy_o[0], busy_o[1]); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] order;
        int gc [4];
        int n;
        pulse_reset();
        order = 4'b0000; n = 0;
        ld_reg = 5'd2; ld_data = $urandom(); ins_word = make_word(4'b0000, 5'd5, 5'd6, 5'd7);
        ld_valid = 1'b1; ins_valid = 1'b1;
        for (int i = 0; i < 20 && n < 4; i++) begin
            #1;
            checks++;
            if (ld_ready && ins_ready)
                begin errors++; $display("FAIL b2b_onehot: both ready in cycle %0d", cyc); end
            if (ld_ready || ins_ready) begin
                order[3-n] = ld_ready;
                gc[n] = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        ld_valid = 1'b0; ins_valid = 1'b0;
        checks++;
        if (n !== 4 || order !== 4'b1010)
            begin errors++; $display("FAIL b2b_order: grants=%0d order=%b, need 4 1010", n, order); end
        for (int j = 1; j < 4; j++) begin
            checks++;
            if (j < n && gc[j] - gc[j-1] !== 3)
                begin errors++; $display("FAIL b2b_spacing: grant %0d gap %0d, need 3", j, gc[j] - gc[j-1]); end
        end
        repeat (3) @(posedge clk);
        #1;
        exp_ret = 16'd4;
        prefer_ld = 1'b1;
        checks++;
        if (retired !== exp_ret)
            begin errors++; $display("FAIL b2b_retired: got %h, need %h", retired, exp_ret); end
    endtask

    task automatic test_reset_setup();
        logic wen_seen;
        logic rdy;
        ld_reg = 5'd9; ld_data = $urandom(); ld_valid = 1'b1;
        #1;
        rdy = ld_ready;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        checks++;
        if (rdy !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL rsetup_grant: ready=%b busy=%b, need 1 1", rdy, busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 16'd0; prefer_ld = 1'b1;
        checks++;
        if ({dp_ir, dp_data, dp_wen, dp_sel, illegal, busy, retired} !== 86'd0)
            begin errors++; $display("FAIL rsetup_zero: ir=%h data=%h wen=%b sel=%b ill=%b busy=%b ret=%h, need zero",
                                     dp_ir, dp_data, dp_wen, dp_sel, illegal, busy, retired); end
        wen_seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; wen_seen = wen_seen | dp_wen; end
        checks++;
        if (wen_seen !== 1'b0 || retired !== 16'd0)
            begin errors++; $display("FAIL rsetup_abort: wen_seen=%b ret=%h, need 0 0", wen_seen, retired); end
        drive_op(1'b1, 1'b0, 5'd12, 32'hCAFE_0001, 32'h0);
        exp_ret = exp_ret + 16'd1; prefer_ld = 1'b0;
        checks++;
        if (got_ld !== 1'b1 || {wen_o[0], wen_o[1], wen_o[2]} !== 3'b010 || ret_o[2] !== exp_ret
            || data_o[0] !== 32'hCAFE_0001)
            begin errors++; $display("FAIL rsetup_next: got=%b wen=%b%b%b ret=%h data=%h, need 1 010 %h cafe0001",
                                     got_ld, wen_o[0], wen_o[1], wen_o[2], ret_o[2], data_o[0], exp_ret); end
    endtask

    task automatic test_random();
        logic vl, vi, exp_ld, ok;
        logic [3:0] op;
        logic [4:0] r;
        logic [31:0] d, w, e_ir, e_data;
        pulse_reset();
        for (int t = 0; t < 30; t++) begin
            vl = 1'($urandom_range(0, 1));
            vi = 1'($urandom_range(0, 1));
            if (!vl && !vi) vi = 1'b1;
            op = 4'($urandom_range(0, 15));
            r = 5'($urandom_range(0, 31));
            d = $urandom();
            w = ($urandom() & ~(32'hF << OP_LO)) | (32'(op) << OP_LO);
            exp_ld = vl && (!vi || prefer_ld);
            drive_op(vl, vi, r, d, w);
            prefer_ld = !exp_ld;
            e_ir   = exp_ld ? (32'(r) << RC_LO) : w;
            e_data = exp_ld ? d : 32'h0;
            ok     = exp_ld || model_legal(op);
            if (ok) exp_ret = exp_ret + 16'd1;
            checks++;
            if ({got_ld, got_ins} !== {exp_ld, !exp_ld})
                begin errors++; $display("FAIL rnd_grant[%0d]: got ld=%b ins=%b, need %b%b", t, got_ld, got_ins, exp_ld, !exp_ld); end
            checks++;
            if (ir_o[0] !== e_ir || data_o[0] !== e_data || sel_o[0] !== exp_ld || ir_o[2] !== e_ir)
                begin errors++; $display("FAIL rnd_latch[%0d]: ir=%h data=%h sel=%b, need %h %h %b",
                                         t, ir_o[0], data_o[0], sel_o[0], e_ir, e_data, exp_ld); end
            checks++;
            if ({wen_o[0], wen_o[1], wen_o[2]} !== (ok ? 3'b010 : 3'b000)
                || {ill_o[0], ill_o[1], ill_o[2]} !== (ok ? 3'b000 : 3'b010))
                begin errors++; $display("FAIL rnd_ctrl[%0d]: wen=%b%b%b ill=%b%b%b legal=%b",
                                         t, wen_o[0], wen_o[1], wen_o[2], ill_o[0], ill_o[1], ill_o[2], ok); end
            checks++;
            if (ret_o[2] !== exp_ret || bsy_rdy !== 1'b0)
                begin errors++; $display("FAIL rnd_ret[%0d]: ret=%h ready_while_busy=%b, need %h 0", t, ret_o[2], bsy_rdy, exp_ret); end
        end
    endtask

    task automatic test_wrap();
        force dut.retired_r = 16'hFFFF;
        #1;
        release dut.retired_r;
        exp_ret = 16'hFFFF;
        drive_op(1'b1, 1'b0, 5'd1, 32'h1234_5678, 32'h0);
        exp_ret = exp_ret + 16'd1;
        checks++;
        if (got_ld !== 1'b1 || ret_o[2] !== 16'h0000 || ret_o[2] !== exp_ret)
            begin errors++; $display("FAIL wrap_retired: got=%b ret=%h, need 1 0000", got_ld, ret_o[2]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_instr();
        test_illegal();
        test_back_to_back();
        test_reset_setup();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
